// File: rtl/rfetch_ctrl_pkg.sv
// Shared types for the register-fetch stage: register/word types, the
// execute-bound operand packet and a writeback-match helper.
// Optional feature macro used by this codebase slice: RFETCH_BYPASS_EN.
package rfetch_ctrl_pkg;

    localparam int RVGA_NUM_REGS = 32;

    typedef logic [4:0]  rvga_reg;
    typedef logic [31:0] rvga_word;

    // Operands and destination info registered toward execute; the opaque
    // payload travels in its own register because its width is a parameter.
    typedef struct packed {
        rvga_word rs1_data;
        rvga_word rs2_data;
        rvga_reg  rd;
        logic     rd_w_v;
    } rfetch_exe_pkt_s;

    // True when a valid, non-x0 writeback targets register r this cycle.
    function automatic logic wb_hit(input logic wb_v, input rvga_reg wb_rd, input rvga_reg r);
        return wb_v && (wb_rd != '0) && (wb_rd == r);
    endfunction

endpackage

// File: rtl/rfetch_ctrl_if.sv
// Decode->rfetch and rfetch->execute handshake bundle.
// Handshake rule: a transfer happens on a rising edge where the producer's
// valid and the consumer's ready are both high; the producer holds its data
// stable while valid is high and ready is low.
interface rfetch_ctrl_if #(parameter int payload_width_p = 64);
    import rfetch_ctrl_pkg::*;

    logic                       dec_v_i;
    logic                       dec_ready_o;
    rvga_reg                    dec_rs1_i;
    rvga_reg                    dec_rs2_i;
    logic                       dec_rs1_v_i;
    logic                       dec_rs2_v_i;
    rvga_reg                    dec_rd_i;
    logic                       dec_rd_w_v_i;
    logic [payload_width_p-1:0] dec_payload_i;

    logic                       exe_v_o;
    logic                       exe_ready_i;
    rvga_word                   exe_rs1_data_o;
    rvga_word                   exe_rs2_data_o;
    rvga_reg                    exe_rd_o;
    logic                       exe_rd_w_v_o;
    logic [payload_width_p-1:0] exe_payload_o;

    // The fetch stage itself.
    modport slave (
        input  dec_v_i, dec_rs1_i, dec_rs2_i, dec_rs1_v_i, dec_rs2_v_i,
        input  dec_rd_i, dec_rd_w_v_i, dec_payload_i, exe_ready_i,
        output dec_ready_o, exe_v_o, exe_rs1_data_o, exe_rs2_data_o,
        output exe_rd_o, exe_rd_w_v_o, exe_payload_o
    );

    // Decode/execute side surrounding the stage.
    modport master (
        output dec_v_i, dec_rs1_i, dec_rs2_i, dec_rs1_v_i, dec_rs2_v_i,
        output dec_rd_i, dec_rd_w_v_i, dec_payload_i, exe_ready_i,
        input  dec_ready_o, exe_v_o, exe_rs1_data_o, exe_rs2_data_o,
        input  exe_rd_o, exe_rd_w_v_o, exe_payload_o
    );

endinterface

// File: rtl/rfetch_dp.sv
// Architectural register file: two combinational read ports, one write port
// committed at the clock edge. x0 always reads zero and ignores writes.
module rfetch_dp
    import rfetch_ctrl_pkg::*;
#(
    parameter int els_p = RVGA_NUM_REGS
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  rvga_reg  rs1_addr_i,
    input  rvga_reg  rs2_addr_i,
    output rvga_word rs1_data_o,
    output rvga_word rs2_data_o,
    input  logic     w_v_i,
    input  rvga_reg  w_addr_i,
    input  rvga_word w_data_i
);

    rvga_word mem_q [els_p];

    // Register storage; writes to x0 are dropped so it stays zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
        end else if (w_v_i && (w_addr_i != '0)) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 : mem_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 : mem_q[rs2_addr_i];

endmodule

// File: rtl/rfetch_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set when an instr that
// writes rd is accepted, cleared by writeback or by flushing the held instr.
// With RFETCH_BYPASS_EN, a register being written back this cycle is not a hazard.
module rfetch_scoreboard
    import rfetch_ctrl_pkg::*;
#(
    parameter int els_p = RVGA_NUM_REGS
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             set_v_i,
    input  rvga_reg          set_rd_i,
    input  logic             clr_v_i,
    input  rvga_reg          clr_rd_i,
    input  logic             kill_v_i,
    input  rvga_reg          kill_rd_i,
    input  logic             rs1_v_i,
    input  rvga_reg          rs1_i,
    input  logic             rs2_v_i,
    input  rvga_reg          rs2_i,
    input  logic             rd_w_v_i,
    input  rvga_reg          rd_i,
    output logic             hazard_o,
    output logic [els_p-1:0] busy_o
);

    logic [els_p-1:0] busy_q, busy_d;
    logic rs1_busy, rs2_busy, rd_busy;

    // Next busy vector: clears first, then set, so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_v_i)  busy_d[clr_rd_i]  = 1'b0;
        if (kill_v_i) busy_d[kill_rd_i] = 1'b0;
        if (set_v_i && (set_rd_i != '0)) busy_d[set_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    // Hazard lookup for the instr currently offered by decode.
    always_comb begin
        rs1_busy = busy_q[rs1_i];
        rs2_busy = busy_q[rs2_i];
        rd_busy  = busy_q[rd_i];
`ifdef RFETCH_BYPASS_EN
        if (wb_hit(clr_v_i, clr_rd_i, rs1_i)) rs1_busy = 1'b0;
        if (wb_hit(clr_v_i, clr_rd_i, rs2_i)) rs2_busy = 1'b0;
        if (wb_hit(clr_v_i, clr_rd_i, rd_i))  rd_busy  = 1'b0;
`endif
        hazard_o = (rs1_v_i & rs1_busy) | (rs2_v_i & rs2_busy) | (rd_w_v_i & rd_busy);
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rfetch_ctrl.sv
// Register-fetch stage controller: hazard-checked accept from decode, register
// read, and a one-entry EMPTY/FULL output stage toward execute.
// Optional feature macro: RFETCH_BYPASS_EN (forward same-cycle writeback data).
module rfetch_ctrl
    import rfetch_ctrl_pkg::*;
#(
    parameter int els_p           = RVGA_NUM_REGS,
    parameter int payload_width_p = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    rfetch_ctrl_if.slave     bus,
    input  logic             flush_i,
    input  logic             writeback_rd_w_v_i,
    input  rvga_reg          writeback_rd_i,
    input  rvga_word         writeback_rd_data_i,
    output logic [0:0]       state_o,
    output logic [els_p-1:0] busy_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]                 state_q, state_d;
    rfetch_exe_pkt_s            pkt_q, pkt_d;
    logic [payload_width_p-1:0] payload_q;
    rvga_word                   rf_rs1, rf_rs2;
    logic                       hazard, accept, kill_v;

    rfetch_dp #(.els_p(els_p)) u_dp (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rs1_addr_i (bus.dec_rs1_i),
        .rs2_addr_i (bus.dec_rs2_i),
        .rs1_data_o (rf_rs1),
        .rs2_data_o (rf_rs2),
        .w_v_i      (writeback_rd_w_v_i),
        .w_addr_i   (writeback_rd_i),
        .w_data_i   (writeback_rd_data_i)
    );

    // A held instr killed before execute took it releases its busy bit.
    assign kill_v = flush_i & (state_q == ST_FULL) & ~bus.exe_ready_i & pkt_q.rd_w_v;

    rfetch_scoreboard #(.els_p(els_p)) u_sb (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .set_v_i  (accept & bus.dec_rd_w_v_i),
        .set_rd_i (bus.dec_rd_i),
        .clr_v_i  (writeback_rd_w_v_i),
        .clr_rd_i (writeback_rd_i),
        .kill_v_i (kill_v),
        .kill_rd_i(pkt_q.rd),
        .rs1_v_i  (bus.dec_rs1_v_i),
        .rs1_i    (bus.dec_rs1_i),
        .rs2_v_i  (bus.dec_rs2_v_i),
        .rs2_i    (bus.dec_rs2_i),
        .rd_w_v_i (bus.dec_rd_w_v_i),
        .rd_i     (bus.dec_rd_i),
        .hazard_o (hazard),
        .busy_o   (busy_o)
    );

    assign bus.dec_ready_o = ~hazard & ~flush_i & ((state_q == ST_EMPTY) | bus.exe_ready_i);
    assign accept          = bus.dec_v_i & bus.dec_ready_o;

    // Operand selection and output-stage next state.
    always_comb begin
        pkt_d.rs1_data = rf_rs1;
        pkt_d.rs2_data = rf_rs2;
`ifdef RFETCH_BYPASS_EN
        if (wb_hit(writeback_rd_w_v_i, writeback_rd_i, bus.dec_rs1_i)) pkt_d.rs1_data = writeback_rd_data_i;
        if (wb_hit(writeback_rd_w_v_i, writeback_rd_i, bus.dec_rs2_i)) pkt_d.rs2_data = writeback_rd_data_i;
`endif
        pkt_d.rd     = bus.dec_rd_i;
        pkt_d.rd_w_v = bus.dec_rd_w_v_i;

        state_d = state_q;
        if (flush_i)               state_d = ST_EMPTY;
        else if (accept)           state_d = ST_FULL;
        else if (bus.exe_ready_i)  state_d = ST_EMPTY;
    end

    // Output stage: loads only on accept, so a stalled entry stays stable.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_EMPTY;
            pkt_q     <= '0;
            payload_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pkt_q     <= pkt_d;
                payload_q <= bus.dec_payload_i;
            end
        end
    end

    assign bus.exe_v_o        = (state_q == ST_FULL);
    assign bus.exe_rs1_data_o = pkt_q.rs1_data;
    assign bus.exe_rs2_data_o = pkt_q.rs2_data;
    assign bus.exe_rd_o       = pkt_q.rd;
    assign bus.exe_rd_w_v_o   = pkt_q.rd_w_v;
    assign bus.exe_payload_o  = payload_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_rfetch_ctrl.sv
// Directed bench for rfetch_ctrl: reset, RAW stall/release, backpressure,
// flush, x0 handling, set-vs-clear priority and asynchronous reset mid-stall.
module tb_rfetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [0:0]  state_dbg;
    logic [31:0] busy_dbg;
    int          checks;
    int          failures;

    rfetch_ctrl_if #(.payload_width_p(64)) bus ();

    rfetch_ctrl #(.els_p(32), .payload_width_p(64)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .bus                 (bus),
        .flush_i             (flush),
        .writeback_rd_w_v_i  (wb_v),
        .writeback_rd_i      (wb_rd),
        .writeback_rd_data_i (wb_data),
        .state_o             (state_dbg),
        .busy_o              (busy_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic rs1_v, input logic [4:0] rs2,
                         input logic rs2_v, input logic [4:0] rd, input logic rd_w_v,
                         input logic [63:0] pl);
        bus.dec_v_i      = 1'b1;
        bus.dec_rs1_i    = rs1;
        bus.dec_rs1_v_i  = rs1_v;
        bus.dec_rs2_i    = rs2;
        bus.dec_rs2_v_i  = rs2_v;
        bus.dec_rd_i     = rd;
        bus.dec_rd_w_v_i = rd_w_v;
        bus.dec_payload_i = pl;
    endtask

    task automatic idle();
        bus.dec_v_i      = 1'b0;
        bus.dec_rs1_v_i  = 1'b0;
        bus.dec_rs2_v_i  = 1'b0;
        bus.dec_rd_w_v_i = 1'b0;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] data);
        wb_v    = v;
        wb_rd   = rd;
        wb_data = data;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0);
        idle();
        bus.exe_ready_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exe_v", bus.exe_v_o, 1'b0);
        chk("rst_rs1_data", bus.exe_rs1_data_o, 32'd0);
        chk("rst_payload", bus.exe_payload_o, 64'd0);
        chk("rst_busy", busy_dbg, 32'd0);
        chk("rst_state", state_dbg, 1'b0);
        chk("rst_ready", bus.dec_ready_o, 1'b1);
        rst_n = 1'b1;
        tick();

        // 1: x5=7 by writeback, then add rs1=x5 rd=x6
        wb(1'b1, 5'd5, 32'd7);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 64'h1111);
        #1 chk("t1_ready", bus.dec_ready_o, 1'b1);
        tick();
        idle();
        chk("t1_exe_v", bus.exe_v_o, 1'b1);
        chk("t1_rs1_data", bus.exe_rs1_data_o, 32'd7);
        chk("t1_rd", bus.exe_rd_o, 5'd6);
        chk("t1_rd_w_v", bus.exe_rd_w_v_o, 1'b1);
        chk("t1_payload", bus.exe_payload_o, 64'h1111);
        chk("t1_busy", busy_dbg, 32'h0000_0040);

        // 2: rs1=x6 stalls until writeback x6=9
        issue(5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 64'h2222);
        #1 chk("t2_stall_a", bus.dec_ready_o, 1'b0);
        tick();
        chk("t2_drained", bus.exe_v_o, 1'b0);
        chk("t2_stall_b", bus.dec_ready_o, 1'b0);
        wb(1'b1, 5'd6, 32'd9);
        #1;
`ifdef RFETCH_BYPASS_EN
        chk("t2_bypass_ready", bus.dec_ready_o, 1'b1);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        idle();
`else
        chk("t2_wb_cycle_stall", bus.dec_ready_o, 1'b0);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        #1 chk("t2_ready_after_wb", bus.dec_ready_o, 1'b1);
        tick();
        idle();
`endif
        chk("t2_exe_v", bus.exe_v_o, 1'b1);
        chk("t2_rs1_data", bus.exe_rs1_data_o, 32'd9);
        chk("t2_payload", bus.exe_payload_o, 64'h2222);
        chk("t2_busy", busy_dbg, 32'h0000_0080);

        // 3: backpressure for 3 cycles, then back-to-back issue
        bus.exe_ready_i = 1'b0;
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 64'h3333);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_hold_ready", bus.dec_ready_o, 1'b0);
            tick();
            chk("t3_hold_v", bus.exe_v_o, 1'b1);
            chk("t3_hold_payload", bus.exe_payload_o, 64'h2222);
            chk("t3_hold_rs1", bus.exe_rs1_data_o, 32'd9);
        end
        bus.exe_ready_i = 1'b1;
        #1 chk("t3_release_ready", bus.dec_ready_o, 1'b1);
        tick();
        chk("t3_b2b_payload_a", bus.exe_payload_o, 64'h3333);
        chk("t3_b2b_rs1_a", bus.exe_rs1_data_o, 32'd7);
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 64'h4444);
        #1 chk("t3_b2b_ready", bus.dec_ready_o, 1'b1);
        tick();
        idle();
        chk("t3_b2b_v", bus.exe_v_o, 1'b1);
        chk("t3_b2b_payload_b", bus.exe_payload_o, 64'h4444);
        chk("t3_b2b_rs1_b", bus.exe_rs1_data_o, 32'd0);
        chk("t3_busy", busy_dbg, 32'h0000_0380);

        // 4: flush a held rd=x10 instr while x11 is offered
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 64'h5555);
        tick();
        idle();
        chk("t4_held_payload", bus.exe_payload_o, 64'h5555);
        chk("t4_held_busy", busy_dbg, 32'h0000_0780);
        bus.exe_ready_i = 1'b0;
        flush = 1'b1;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 64'h6666);
        #1 chk("t4_flush_ready", bus.dec_ready_o, 1'b0);
        tick();
        flush = 1'b0;
        idle();
        bus.exe_ready_i = 1'b1;
        chk("t4_exe_v", bus.exe_v_o, 1'b0);
        chk("t4_busy", busy_dbg, 32'h0000_0380);
        chk("t4_state", state_dbg, 1'b0);

        // 5: rd=x0 instr plus writeback to x0
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 64'h7777);
        wb(1'b1, 5'd0, 32'hdead_beef);
        #1 chk("t5_ready", bus.dec_ready_o, 1'b1);
        tick();
        idle();
        wb(1'b0, 5'd0, 32'd0);
        chk("t5_exe_v", bus.exe_v_o, 1'b1);
        chk("t5_rs1_zero", bus.exe_rs1_data_o, 32'd0);
        chk("t5_rs2_zero", bus.exe_rs2_data_o, 32'd0);
        chk("t5_busy", busy_dbg, 32'h0000_0380);
        issue(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 64'h8888);
        tick();
        idle();
        chk("t5_x0_after_wb", bus.exe_rs2_data_o, 32'd0);
        chk("t5_payload", bus.exe_payload_o, 64'h8888);

        // 6: same-cycle set and clear of x3, then reset mid-stall
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'h9999);
        wb(1'b1, 5'd3, 32'h55);
        #1 chk("t6_ready", bus.dec_ready_o, 1'b1);
        tick();
        idle();
        wb(1'b0, 5'd0, 32'd0);
        chk("t6_set_wins", busy_dbg, 32'h0000_0388);
        bus.exe_ready_i = 1'b0;
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 64'haaaa);
        #1 chk("t6_stall", bus.dec_ready_o, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_exe_v", bus.exe_v_o, 1'b0);
        chk("t6_rst_busy", busy_dbg, 32'd0);
        chk("t6_rst_payload", bus.exe_payload_o, 64'd0);
        chk("t6_rst_state", state_dbg, 1'b0);
        chk("t6_rst_ready", bus.dec_ready_o, 1'b1);
        idle();
        bus.exe_ready_i = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_rst_busy", busy_dbg, 32'd0);
        chk("t6_post_rst_exe_v", bus.exe_v_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
